rtc_calendar_core: RTL
======================

Name: rtc_calendar_core

Overview:
Parametrised successor to the clock's time/date counter. It keeps BCD hh:mm:ss and yy-mm-dd in one clock domain and derives the 1 s tick internally from a divider. Over the first-generation counter it adds leap-year February, validated time/date load with error reporting, an alarm comparator and a parametrised hourly chime. It feeds the display mux and the LED/buzzer drivers.

Parameters:
CLK_DIV, 50_000_000, clk cycles per second; must be >= 2.
RST_TIME, 24'h235649, BCD {hh,mm,ss} loaded on reset.
RST_DATE, 24'h201228, BCD {yy,mm,dd} loaded on reset; yy = 2000+yy.
CHIME_SECS, 10, number of seconds chime stays high after each full hour (1..59).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
load_time  in  1  one-cycle strobe: load time_in
time_in  in  24  BCD {hh,mm,ss}
load_date  in  1  one-cycle strobe: load date_in
date_in  in  24  BCD {yy,mm,dd}
alarm_en  in  1  alarm compare enable
alarm_time  in  24  BCD {hh,mm,ss}
time_bcd  out  24  current time
date_bcd  out  24  current date
sec_pulse  out  1  one-cycle pulse per second increment
day_pulse  out  1  one-cycle pulse on midnight rollover
alarm_hit  out  1  one-cycle pulse on alarm match
chime  out  1  level, hourly chime window
load_err  out  1  one-cycle pulse, rejected load

Behaviour:
- One clock, rst synchronous and active-high. All outputs are registered.
- Reset: time_bcd=RST_TIME, date_bcd=RST_DATE, divider=0, all pulses 0, chime=0.
- Divider: counts 0..CLK_DIV-1. The cycle where it wraps is the tick, so the first tick after reset occurs CLK_DIV cycles later.
- On tick: ss+1, with BCD carry into mm and hh. sec_pulse=1 in the cycle the new time appears.
- 23:59:59 + tick -> 00:00:00. The date advances in the same cycle and day_pulse=1.
- Days per month: 31 for 01/03/05/07/08/10/12; 30 for 04/06/09/11; 28 for 02, or 29 when leap.
- Leap rule in BCD: yy tens digit even and units in {0,4,8}, or tens digit odd and units in {2,6}. 2000 is a leap year.
- Last day of a month + rollover -> day 01, next month. 09 -> 10 and 12 -> 01 carry correctly in BCD.
- 99-12-31 rollover -> 00-01-01 (wraps, no error).
- Time load: accepted if every digit <= 9, hh <= 23, mm <= 59, ss <= 59.
  - Applied next cycle and divider cleared to 0, so the next tick is a full second later.
  - A tick in the same cycle is discarded.
- Date load: accepted if digits <= 9, mm in 01..12, and dd in 01..days_in_month computed from date_in's own yy/mm.
  - A date load wins over a same-cycle midnight advance; time still rolls to 00:00:00.
  - day_pulse still asserts.
- Rejected load: state unchanged, load_err=1 for one cycle. If both loads arrive and one is bad, the good one still applies.
- Alarm: alarm_hit=1 for one cycle when alarm_en=1 and a tick or accepted load makes time_bcd equal alarm_time. It does not repeat while time is static.
- Chime: set when time becomes mm=00, ss=00 by tick or load. Cleared on the tick that makes ss equal CHIME_SECS, or by reset.
- Never outputs non-BCD or out-of-range values; default/illegal internal states recover to RST values.

Test Plan:
- Reset, CLK_DIV=4 -> time 23:56:49, date 20-12-28. First sec_pulse at cycle 4 after rst release; time 23:56:50.
- Load time 23:59:59, date 24-02-28, run one tick -> 00:00:00, 24-02-29, day_pulse=1. Next midnight -> 24-03-01.
- Load date 23-02-28 and roll midnight -> 23-03-01. Load 99-12-31 23:59:59 + tick -> 00-01-01 00:00:00.
- Load time 24:00:00 -> load_err=1, time unchanged. Load date 23-02-29 -> load_err=1. Load date 24-02-29 -> accepted.
- alarm_en=1, alarm 00:00:02, start 23:59:59 -> single alarm_hit at 00:00:02. alarm_en=0 -> no pulse.
- CHIME_SECS=3, start 12:59:58 -> chime rises at 13:00:00, falls at 13:00:03. A load_time landing on a tick cycle yields no increment and a full-second gap.

Source files
------------

// File: rtl/rtc_calendar_core.sv
// BCD real-time clock/calendar: internal 1 s divider, hh:mm:ss + yy-mm-dd with leap years,
// validated loads with error pulse, alarm comparator and hourly chime window.
module rtc_calendar_core #(
    parameter int unsigned CLK_DIV    = 50_000_000,
    parameter logic [23:0] RST_TIME   = 24'h235649,
    parameter logic [23:0] RST_DATE   = 24'h201228,
    parameter int unsigned CHIME_SECS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_time,
    input  logic [23:0] time_in,
    input  logic        load_date,
    input  logic [23:0] date_in,
    input  logic        alarm_en,
    input  logic [23:0] alarm_time,
    output logic [23:0] time_bcd,
    output logic [23:0] date_bcd,
    output logic        sec_pulse,
    output logic        day_pulse,
    output logic        alarm_hit,
    output logic        chime,
    output logic        load_err
);

    localparam int unsigned   DIV_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]    CHIME_BCD = {4'(CHIME_SECS / 10), 4'(CHIME_SECS % 10)};

    // ---------------------------------------------------------------- BCD helpers
    function automatic logic digits_ok(input logic [23:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Leap years within 2000..2099 are exactly the multiples of four.
    function automatic logic is_leap(input logic [7:0] yy);
        if (!yy[4]) return (yy[3:0] == 4'd0) || (yy[3:0] == 4'd4) || (yy[3:0] == 4'd8);
        return (yy[3:0] == 4'd2) || (yy[3:0] == 4'd6);
    endfunction

    function automatic logic [7:0] month_days(input logic [7:0] yy, input logic [7:0] mm);
        logic [7:0] d;
        case (mm)
            8'h02:                      d = is_leap(yy) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
            default:                    d = 8'h31;
        endcase
        return d;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic time_ok(input logic [23:0] t);
        return digits_ok(t) && (t[23:16] <= 8'h23) && (t[15:8] <= 8'h59) && (t[7:0] <= 8'h59);
    endfunction

    function automatic logic date_ok(input logic [23:0] d);
        return digits_ok(d) && (d[15:8] >= 8'h01) && (d[15:8] <= 8'h12) &&
               (d[7:0] >= 8'h01) && (d[7:0] <= month_days(d[23:16], d[15:8]));
    endfunction

    function automatic logic [23:0] time_next(input logic [23:0] t);
        logic [7:0] hh, mm, ss;
        hh = t[23:16];
        mm = t[15:8];
        ss = t[7:0];
        if (ss != 8'h59) begin
            ss = bcd_inc(ss);
        end else begin
            ss = 8'h00;
            if (mm != 8'h59) begin
                mm = bcd_inc(mm);
            end else begin
                mm = 8'h00;
                hh = (hh == 8'h23) ? 8'h00 : bcd_inc(hh);
            end
        end
        return {hh, mm, ss};
    endfunction

    function automatic logic [23:0] date_next(input logic [23:0] d);
        logic [7:0] yy, mm, dd;
        yy = d[23:16];
        mm = d[15:8];
        dd = d[7:0];
        if (dd != month_days(yy, mm)) begin
            dd = bcd_inc(dd);
        end else begin
            dd = 8'h01;
            if (mm != 8'h12) begin
                mm = bcd_inc(mm);
            end else begin
                mm = 8'h01;
                yy = (yy == 8'h99) ? 8'h00 : bcd_inc(yy);
            end
        end
        return {yy, mm, dd};
    endfunction

    // ---------------------------------------------------------------- state
    logic [DIV_W-1:0] div_q, div_d;
    logic [23:0]      time_q, time_d;
    logic [23:0]      date_q, date_d;
    logic             sec_pulse_q, sec_pulse_d;
    logic             day_pulse_q, day_pulse_d;
    logic             alarm_hit_q, alarm_hit_d;
    logic             chime_q, chime_d;
    logic             load_err_q, load_err_d;

    logic        tick_c;
    logic        time_ld_ok_c;
    logic        date_ld_ok_c;
    logic        tick_apply_c;
    logic        midnight_c;
    logic        time_upd_c;
    logic [23:0] time_cur_c;
    logic [23:0] date_cur_c;

    // Next-state: loads override the tick; a corrupted register falls back to its reset value.
    always_comb begin
        tick_c       = (div_q == DIV_LAST);
        time_ld_ok_c = load_time && time_ok(time_in);
        date_ld_ok_c = load_date && date_ok(date_in);
        time_cur_c   = time_ok(time_q) ? time_q : RST_TIME;
        date_cur_c   = date_ok(date_q) ? date_q : RST_DATE;
        tick_apply_c = tick_c && !time_ld_ok_c;
        midnight_c   = tick_apply_c && (time_cur_c == 24'h235959);
        time_upd_c   = tick_apply_c || time_ld_ok_c;

        div_d       = tick_c ? '0 : div_q + DIV_W'(1);
        time_d      = time_cur_c;
        date_d      = date_cur_c;
        sec_pulse_d = 1'b0;
        day_pulse_d = midnight_c;
        load_err_d  = (load_time && !time_ld_ok_c) || (load_date && !date_ld_ok_c);
        chime_d     = chime_q;

        if (time_ld_ok_c) begin
            time_d = time_in;
            div_d  = '0;
        end else if (tick_c) begin
            time_d      = time_next(time_cur_c);
            sec_pulse_d = 1'b1;
            if (midnight_c) date_d = date_next(date_cur_c);
        end

        if (date_ld_ok_c) date_d = date_in;

        alarm_hit_d = alarm_en && time_upd_c && (time_d == alarm_time);

        if (time_upd_c && (time_d[15:0] == 16'h0000)) begin
            chime_d = 1'b1;
        end else if (tick_apply_c && (time_d[7:0] == CHIME_BCD)) begin
            chime_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            time_q      <= RST_TIME;
            date_q      <= RST_DATE;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            alarm_hit_q <= 1'b0;
            chime_q     <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            time_q      <= time_d;
            date_q      <= date_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
            alarm_hit_q <= alarm_hit_d;
            chime_q     <= chime_d;
            load_err_q  <= load_err_d;
        end
    end

    assign time_bcd  = time_q;
    assign date_bcd  = date_q;
    assign sec_pulse = sec_pulse_q;
    assign day_pulse = day_pulse_q;
    assign alarm_hit = alarm_hit_q;
    assign chime     = chime_q;
    assign load_err  = load_err_q;

endmodule
